baud_generator: RTL and testbench

Clock-enable generator for the USART. Derives the one-cycle `i_txclk` enable for the transmitter, and the sample enable for the receiver, from the system clock, the 12-bit UBRR divisor and the mode bits. In synchronous master mode it also drives the XCK pin. In synchronous slave mode it derives both enables from the synchronised external XCK.

---
 rtl/baud_generator.sv | 101 ++++++++++
 tb/tb_baud_generator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_generator.sv
// baud_generator: USART transmit/receive clock-enable and XCK generator
module baud_generator (
    input  logic        i_fosk,
    input  logic        i_rst_n,
    input  logic [11:0] i_ubrr,
    input  logic        i_we_ubrr,
    input  logic        i_u2x,
    input  logic        i_umsel,
    input  logic        i_ucpol,
    input  logic        i_xck_ddr,
    input  logic        i_xck,
    input  logic        i_TXEN,
    input  logic        i_RXEN,
    output logic        o_txclk,
    output logic        o_rxclk,
    output logic        o_xck,
    output logic        o_xck_oe
);
    logic [11:0] cnt;
    logic [3:0]  presc;
    logic [3:0]  mode_q;
    logic        xck, s1, s2, s3, tx_q, rx_q, en_q;
    logic        en, master, slave, mode_chg, base_tick;
    logic        rise, fall, tx_edge, rx_edge, tx_tick, rx_tick;

    assign en        = i_TXEN | i_RXEN;
    assign master    = i_umsel & i_xck_ddr;
    assign slave     = i_umsel & ~i_xck_ddr;
    // a mode change only counts when enable was already high, so reset or enable never look like one
    assign mode_chg  = en & en_q & (mode_q != {i_umsel, i_xck_ddr, i_ucpol, i_u2x});
    assign base_tick = en & ~mode_chg & ~i_we_ubrr & ~slave & (cnt == '0);
    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign tx_edge   = i_ucpol ? fall : rise;
    assign rx_edge   = i_ucpol ? rise : fall;
    assign o_txclk   = tx_q & en;
    assign o_rxclk   = rx_q & en;
    assign o_xck     = xck ^ i_ucpol;
    assign o_xck_oe  = master & en;

    // select which event drives each enable; the internal xck rising tick is always the transmit edge
    always_comb begin
        tx_tick = 1'b0;
        rx_tick = 1'b0;
        if (en && !mode_chg) begin
            tx_tick = slave ? tx_edge : master ? (base_tick & ~xck) : (base_tick & (i_u2x ? presc[2:0] == 3'd7 : presc == 4'd15));
            rx_tick = slave ? rx_edge : master ? (base_tick & xck) : base_tick;
        end
    end

    // base divider, oversample prescaler and master XCK toggle
    always_ff @(posedge i_fosk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= '0;
            presc <= '0;
            xck   <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            presc <= '0;
            xck   <= 1'b0;
        end else if (i_we_ubrr || mode_chg || slave) begin
            cnt   <= i_ubrr;
            presc <= '0;
            xck   <= xck & ~(mode_chg | slave);
        end else if (cnt == '0) begin
            cnt   <= i_ubrr;
            presc <= presc + 4'd1;
            xck   <= master & ~xck;
        end else begin
            cnt   <= cnt - 12'd1;
        end
    end

    // XCK pin synchroniser, edge-detect flop and mode history
    always_ff @(posedge i_fosk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            en_q   <= 1'b0;
            mode_q <= '0;
        end else begin
            s1     <= i_xck;
            s2     <= s1;
            s3     <= s2;
            en_q   <= en;
            mode_q <= {i_umsel, i_xck_ddr, i_ucpol, i_u2x};
        end
    end

    // registered one-cycle output pulses
    always_ff @(posedge i_fosk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_q <= 1'b0;
            rx_q <= 1'b0;
        end else begin
            tx_q <= tx_tick;
            rx_q <= rx_tick;
        end
    end
endmodule

// File: tb/tb_baud_generator.sv
// tb_baud_generator: table, directed and randomized checks of baud_generator
module tb_baud_generator;
    logic        i_fosk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [11:0] i_ubrr = '0;
    logic        i_we_ubrr = 1'b0;
    logic        i_u2x = 1'b0;
    logic        i_umsel = 1'b0;
    logic        i_ucpol = 1'b0;
    logic        i_xck_ddr = 1'b0;
    logic        i_xck = 1'b0;
    logic        i_TXEN = 1'b0;
    logic        i_RXEN = 1'b0;
    logic        o_txclk, o_rxclk, o_xck, o_xck_oe;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int u;
        int u2x;
        int umsel;
        int ucpol;
        int rx_first;
        int rx_per;
        int tx_first;
        int tx_per;
        int oe;
    } vec_t;

    vec_t tbl[5];
    logic pin[0:159];

    always #5 i_fosk = ~i_fosk;

    baud_generator dut (
        .i_fosk(i_fosk),
        .i_rst_n(i_rst_n),
        .i_ubrr(i_ubrr),
        .i_we_ubrr(i_we_ubrr),
        .i_u2x(i_u2x),
        .i_umsel(i_umsel),
        .i_ucpol(i_ucpol),
        .i_xck_ddr(i_xck_ddr),
        .i_xck(i_xck),
        .i_TXEN(i_TXEN),
        .i_RXEN(i_RXEN),
        .o_txclk(o_txclk),
        .o_rxclk(o_rxclk),
        .o_xck(o_xck),
        .o_xck_oe(o_xck_oe)
    );

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic step;
        @(posedge i_fosk);
        #1;
    endtask

    task automatic setup(input int u, input int u2x, input int umsel, input int ddr, input int ucpol);
        i_TXEN    = 1'b0;
        i_RXEN    = 1'b0;
        i_we_ubrr = 1'b0;
        i_ubrr    = u[11:0];
        i_u2x     = u2x[0];
        i_umsel   = umsel[0];
        i_xck_ddr = ddr[0];
        i_ucpol   = ucpol[0];
        i_xck     = 1'b0;
        repeat (3) step;
    endtask

    function automatic logic periodic(input int k, input int first, input int per);
        return k >= first && (k - first) % per == 0;
    endfunction

    // cycle k = k-th enabled cycle; ticks fall in cycles 1, 1+(u+1), ... and show on the outputs one cycle later
    function automatic void model(input int k, input int u, input int u2x, input int umsel, input int ucpol,
                                  output logic rx, output logic tx, output logic xck);
        int j;
        logic hit;
        hit = k >= 2 && (k - 2) % (u + 1) == 0;
        j   = hit ? (k - 2) / (u + 1) : 0;
        if (umsel == 0) begin
            rx  = hit;
            tx  = hit && (u2x != 0 ? j % 8 == 7 : j % 16 == 15);
            xck = ucpol[0];
        end else begin
            rx  = hit && j % 2 == 1;
            tx  = hit && j % 2 == 0;
            xck = ucpol[0] ^ (k >= 2 && ((k - 2) / (u + 1) + 1) % 2 == 1);
        end
    endfunction

    initial begin
        int   w, h, idx, mode, u, u2x, ucpol, en_sel;
        logic lvl, erx, etx, exck, rs, fl;

        tbl[0] = '{3, 0, 0, 0, 2, 4, 62, 64, 0};
        tbl[1] = '{3, 1, 0, 0, 2, 4, 30, 32, 0};
        tbl[2] = '{0, 0, 0, 0, 2, 1, 17, 16, 0};
        tbl[3] = '{1, 0, 1, 0, 4, 4, 2, 4, 1};
        tbl[4] = '{1, 0, 1, 1, 4, 4, 2, 4, 1};

        // reset state
        i_ucpol = 1'b1;
        #2;
        chk("rst_txclk", 0, o_txclk, 1'b0);
        chk("rst_rxclk", 0, o_rxclk, 1'b0);
        chk("rst_xck_ucpol1", 0, o_xck, 1'b1);
        i_umsel = 1'b1;
        i_xck_ddr = 1'b1;
        i_TXEN = 1'b1;
        #1;
        chk("rst_oe_on", 0, o_xck_oe, 1'b1);
        chk("rst_txclk_en", 0, o_txclk, 1'b0);
        i_TXEN = 1'b0;
        #1;
        chk("rst_oe_off", 0, o_xck_oe, 1'b0);
        i_ucpol = 1'b0;
        #1;
        chk("rst_xck_ucpol0", 0, o_xck, 1'b0);
        step;
        i_rst_n = 1'b1;
        step;

        // table-driven async and master configurations
        for (int t = 0; t < 5; t++) begin
            setup(tbl[t].u, tbl[t].u2x, tbl[t].umsel, 1, tbl[t].ucpol);
            i_TXEN = 1'b1;
            for (int k = 1; k <= 140; k++) begin
                @(negedge i_fosk);
                model(k, tbl[t].u, tbl[t].u2x, tbl[t].umsel, tbl[t].ucpol, erx, etx, exck);
                chk("tbl_rxclk", k, o_rxclk, periodic(k, tbl[t].rx_first, tbl[t].rx_per));
                chk("tbl_txclk", k, o_txclk, periodic(k, tbl[t].tx_first, tbl[t].tx_per));
                chk("tbl_oe", k, o_xck_oe, tbl[t].oe[0]);
                chk("tbl_xck", k, o_xck, exck);
                step;
            end
        end

        // UBRR rewrite from 100 to 5 mid-count
        setup(100, 0, 0, 0, 0);
        i_TXEN = 1'b1;
        w = 30;
        for (int k = 1; k <= w + 110; k++) begin
            i_we_ubrr = (k == w);
            if (k == w) i_ubrr = 12'd5;
            @(negedge i_fosk);
            chk("we_rxclk", k, o_rxclk, k == 2 || periodic(k, w + 7, 6));
            chk("we_txclk", k, o_txclk, k == w + 97);
            step;
        end
        i_we_ubrr = 1'b0;

        // synchronous slave with 5-cycle high/low XCK
        setup(0, 0, 1, 0, 0);
        i_TXEN = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            i_xck = (k >= 6) && ((k - 6) / 5) % 2 == 0;
            @(negedge i_fosk);
            chk("slv_txclk", k, o_txclk, periodic(k, 9, 10));
            chk("slv_rxclk", k, o_rxclk, periodic(k, 14, 10));
            chk("slv_oe", k, o_xck_oe, 1'b0);
            step;
        end

        // reset pulse during an active async count
        setup(3, 0, 0, 0, 0);
        i_TXEN = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge i_fosk);
            chk("pre_rst_rxclk", k, o_rxclk, periodic(k, 2, 4));
            step;
        end
        i_rst_n = 1'b0;
        @(negedge i_fosk);
        chk("midrst_rxclk", 10, o_rxclk, 1'b0);
        chk("midrst_txclk", 10, o_txclk, 1'b0);
        step;
        step;
        i_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_fosk);
            chk("post_rst_rxclk", k, o_rxclk, periodic(k, 2, 4));
            chk("post_rst_txclk", k, o_txclk, 1'b0);
            step;
        end

        // enable dropped and restored through RXEN
        setup(0, 0, 0, 0, 0);
        i_TXEN = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_fosk);
            chk("pre_dis_rxclk", k, o_rxclk, k >= 2);
            step;
        end
        i_TXEN = 1'b0;
        @(negedge i_fosk);
        chk("dis_rxclk_now", 6, o_rxclk, 1'b0);
        step;
        @(negedge i_fosk);
        chk("dis_rxclk_held", 7, o_rxclk, 1'b0);
        step;
        i_RXEN = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_fosk);
            chk("reen_rxclk", k, o_rxclk, periodic(k, 2, 1));
            chk("reen_txclk", k, o_txclk, periodic(k, 17, 16));
            step;
        end

        // randomized configurations against the reference model
        for (int t = 0; t < 12; t++) begin
            mode   = $urandom_range(0, 2);
            u      = $urandom_range(0, 7);
            u2x    = $urandom_range(0, 1);
            ucpol  = $urandom_range(0, 1);
            en_sel = $urandom_range(1, 3);
            idx = 0;
            lvl = 1'b0;
            while (idx < 160) begin
                h = (idx == 0) ? 5 : $urandom_range(2, 6);
                for (int q = 0; q < h && idx < 160; q++) begin
                    pin[idx] = lvl;
                    idx++;
                end
                lvl = ~lvl;
            end
            setup(u, u2x, mode != 0, mode == 1, ucpol);
            i_TXEN = en_sel[0];
            i_RXEN = en_sel[1];
            for (int k = 1; k <= 150; k++) begin
                i_xck = pin[k];
                @(negedge i_fosk);
                if (mode == 2) begin
                    rs   = k >= 4 && pin[k - 3] && !pin[k - 4];
                    fl   = k >= 4 && !pin[k - 3] && pin[k - 4];
                    etx  = ucpol != 0 ? fl : rs;
                    erx  = ucpol != 0 ? rs : fl;
                    exck = ucpol[0];
                end else begin
                    model(k, u, u2x, mode != 0, ucpol, erx, etx, exck);
                end
                chk("rnd_rxclk", k, o_rxclk, erx);
                chk("rnd_txclk", k, o_txclk, etx);
                chk("rnd_xck", k, o_xck, exck);
                chk("rnd_oe", k, o_xck_oe, mode == 1);
                step;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
